// File: rtl/vegeta_output_collector_if.sv
// Row-stream interface between the array's bottom-row adder trees, the
// output collector and the writeback consumer. The collector takes the
// slave side: it receives skewed column sums and hands out aligned rows.
interface vegeta_output_collector_if #(
  parameter int Y_SCALED      = 4,
  parameter int ALPHA         = 4,
  parameter int ADD_DATAWIDTH = 32,
  parameter int ROWS          = 16
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                                         in_valid;
  logic [Y_SCALED-1:0][ALPHA*ADD_DATAWIDTH-1:0] acc_in;
  logic [Y_SCALED*ALPHA*ADD_DATAWIDTH-1:0]      out_data;
  logic [ROW_W-1:0]                             out_row;
  logic                                         out_valid;
  logic                                         out_ready;

  modport master (
    output in_valid, acc_in, out_ready,
    input  out_data, out_row, out_valid
  );

  modport slave (
    input  in_valid, acc_in, out_ready,
    output out_data, out_row, out_valid
  );
endinterface

// File: rtl/vegeta_output_collector.sv
// Output collector for the systolic array: re-aligns skewed column sums,
// accumulates them across K-passes in a row buffer and, on the last pass,
// streams finished rows through a small show-ahead FIFO.
module vegeta_output_collector #(
  parameter int Y_SCALED      = 4,
  parameter int ALPHA         = 4,
  parameter int ADD_DATAWIDTH = 32,
  parameter int SKEW          = 1,
  parameter int ROWS          = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic accumulate,
  input  logic last_pass,
  vegeta_output_collector_if.slave bus,
  output logic busy,
  output logic err_overflow,
  output logic err_protocol
);
  localparam int W      = ADD_DATAWIDTH;
  localparam int WORDS  = Y_SCALED * ALPHA;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W  = $clog2(ROWS + 1);
  localparam int D      = (Y_SCALED - 1) * SKEW;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

  state_t           state, state_next;
  logic             acc_l, last_l;
  logic [CNT_W-1:0] row_cnt;
  logic             start_ok, accept;

  logic             v_al;
  logic [ROW_W-1:0] r_al;
  logic             pipe_busy;
  logic [ALPHA*W-1:0] col_al [Y_SCALED];

  logic [WORDS-1:0][W-1:0] sum;
  logic [WORDS-1:0][W-1:0] row_buf [ROWS];

  logic [WORDS-1:0][W-1:0] fifo_data [FIFO_DEPTH];
  logic [ROW_W-1:0]        fifo_row  [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [FCNT_W-1:0]       count;
  logic                    head_valid, push_req, push, pop, full, drop;

  assign start_ok = start && (state == IDLE);
  assign accept   = bus.in_valid && (state == COLLECT) && (row_cnt < CNT_W'(ROWS));

  // Valid/tag pipe: travels with the row so tag and data meet at the last column
  if (D == 0) begin : g_nopipe
    assign v_al      = accept;
    assign r_al      = row_cnt[ROW_W-1:0];
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    logic [D-1:0]            vp;
    logic [D-1:0][ROW_W-1:0] rp;

    // Shift accepted-row valid and row tag one stage per cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        vp <= '0;
        rp <= '0;
      end else begin
        vp[0] <= accept;
        rp[0] <= row_cnt[ROW_W-1:0];
        for (int k = 1; k < D; k++) begin
          vp[k] <= vp[k-1];
          rp[k] <= rp[k-1];
        end
      end
    end

    assign v_al      = vp[D-1];
    assign r_al      = rp[D-1];
    assign pipe_busy = |vp;
  end

  // Column de-skew: early columns wait so all columns line up with the last one
  for (genvar j = 0; j < Y_SCALED; j++) begin : g_col
    localparam int DEP = (Y_SCALED - 1 - j) * SKEW;
    if (DEP == 0) begin : g_direct
      assign col_al[j] = bus.acc_in[j];
    end else begin : g_delay
      logic [DEP-1:0][ALPHA*W-1:0] dl;

      // Plain data delay line; validity is carried by the tag pipe
      always_ff @(posedge clk) begin
        dl[0] <= bus.acc_in[j];
        for (int k = 1; k < DEP; k++) begin
          dl[k] <= dl[k-1];
        end
      end

      assign col_al[j] = dl[DEP-1];
    end
  end

  // Per-word add onto the stored row, or pass through when overwriting
  always_comb begin
    sum = '0;
    for (int j = 0; j < Y_SCALED; j++) begin
      for (int l = 0; l < ALPHA; l++) begin
        sum[j*ALPHA+l] = acc_l ? row_buf[r_al][j*ALPHA+l] + col_al[j][l*W +: W]
                               : col_al[j][l*W +: W];
      end
    end
  end

  // Row buffer holds partial results between passes; contents need no reset
  always_ff @(posedge clk) begin
    if (v_al) begin
      row_buf[r_al] <= sum;
    end
  end

  assign head_valid = (count != '0);
  assign full       = (count == FCNT_W'(FIFO_DEPTH));
  assign push_req   = v_al && last_l;
  assign pop        = head_valid && bus.out_ready;
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO storage writes; a full FIFO with a same-cycle pop still accepts the row
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= sum;
      fifo_row[wr_ptr]  <= r_al;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_valid ? fifo_data[rd_ptr] : '0;
  assign bus.out_row   = head_valid ? fifo_row[rd_ptr]  : '0;

  // Pass configuration, row counter and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l        <= 1'b0;
      last_l       <= 1'b0;
      row_cnt      <= '0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      if (start_ok) begin
        acc_l   <= accumulate;
        last_l  <= last_pass;
        row_cnt <= '0;
      end else if (accept) begin
        row_cnt <= row_cnt + 1'b1;
      end

      if (drop)          err_overflow <= 1'b1;
      else if (start_ok) err_overflow <= 1'b0;

      if (bus.in_valid && !accept) err_protocol <= 1'b1;
      else if (start_ok)           err_protocol <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: a pass ends once every row is in and the tag pipe has drained
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if ((row_cnt == CNT_W'(ROWS)) && !pipe_busy)
                 state_next = last_l ? FLUSH : IDLE;
      FLUSH:   if (!head_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_vegeta_output_collector.sv
// Scoreboard bench for the output collector: directed passes push expected
// rows into a queue, and an independent monitor pops and compares each row
// the collector hands over.
module tb_vegeta_output_collector;
  localparam int Y     = 4;
  localparam int A     = 4;
  localparam int W     = 32;
  localparam int SKEW  = 1;
  localparam int ROWS  = 16;
  localparam int FD    = 4;
  localparam int WORDS = Y * A;
  localparam int DW    = WORDS * W;

  localparam int P_IDX   = 0;
  localparam int P_FIVE  = 1;
  localparam int P_SEVEN = 2;
  localparam int P_BIG   = 3;
  localparam int P_ONE   = 4;

  localparam int E_IDX    = 0;
  localparam int E_TWELVE = 1;
  localparam int E_WRAP   = 2;

  typedef struct {
    int            row;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, accumulate, last_pass;
  logic busy, err_overflow, err_protocol;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   cyc        = 0;
  int   t_feed     = 0;
  int   first_seen = -1;

  vegeta_output_collector_if #(
    .Y_SCALED(Y), .ALPHA(A), .ADD_DATAWIDTH(W), .ROWS(ROWS)
  ) bus ();

  vegeta_output_collector #(
    .Y_SCALED(Y), .ALPHA(A), .ADD_DATAWIDTH(W), .SKEW(SKEW),
    .ROWS(ROWS), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .accumulate(accumulate),
    .last_pass(last_pass),
    .bus(bus),
    .busy(busy),
    .err_overflow(err_overflow),
    .err_protocol(err_protocol)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic [W-1:0] word_for(input int pat, input int r,
                                            input int j, input int l);
    case (pat)
      P_IDX:   return W'(1000 * l + 100 * r + j);
      P_FIVE:  return 32'd5;
      P_SEVEN: return 32'd7;
      P_BIG:   return (r == 0) ? 32'h7FFF_FFFF : W'(r);
      P_ONE:   return (r == 0) ? 32'd1 : W'(2 * r);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_row(input int kind, input int r);
    logic [DW-1:0] v;
    logic [W-1:0]  w;
    v = '0;
    for (int j = 0; j < Y; j++) begin
      for (int l = 0; l < A; l++) begin
        case (kind)
          E_IDX:    w = W'(1000 * l + 100 * r + j);
          E_TWELVE: w = 32'd12;
          E_WRAP:   w = (r == 0) ? 32'h8000_0000 : W'(3 * r);
          default:  w = '0;
        endcase
        v[(j*A+l)*W +: W] = w;
      end
    end
    return v;
  endfunction

  task automatic push_expected(input int kind, input int r0, input int r1);
    exp_t e;
    for (int r = r0; r <= r1; r++) begin
      e.row  = r;
      e.data = exp_row(kind, r);
      sb.push_back(e);
    end
  endtask

  // Drives n_rows rows with column j lagging column 0 by j cycles
  task automatic apply_stimulus(input int n_rows, input int pat);
    int r;
    for (int c = 0; c < n_rows + Y - 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) t_feed = cyc;
      bus.in_valid = (c < n_rows);
      for (int j = 0; j < Y; j++) begin
        r = c - j;
        for (int l = 0; l < A; l++) begin
          bus.acc_in[j][l*W +: W] = (r >= 0 && r < n_rows) ? word_for(pat, r, j, l)
                                                           : 32'hDEAD_0000;
        end
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input logic acc, input logic last);
    @(posedge clk); #1;
    start      = 1'b1;
    accumulate = acc;
    last_pass  = last;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check_output(name, DW'(busy), DW'(0));
  endtask

  // Monitor: compare every accepted head row against the scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (first_seen < 0 && bus.out_valid === 1'b1) first_seen = cyc;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_output: got row %0d, expected no output", bus.out_row);
        end else begin
          e = sb.pop_front();
          check_output("out_row", DW'(bus.out_row), DW'(e.row));
          check_output("out_data", bus.out_data, e.data);
        end
      end
    end
  end

  // Watchdog so a stuck design still ends the run
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence
  initial begin : main
    rst = 1'b1; start = 1'b0; accumulate = 1'b0; last_pass = 1'b0;
    bus.in_valid = 1'b0; bus.acc_in = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", DW'(busy), DW'(0));
    check_output("rst_out_valid", DW'(bus.out_valid), DW'(0));
    check_output("rst_out_row", DW'(bus.out_row), DW'(0));
    check_output("rst_out_data", bus.out_data, DW'(0));
    check_output("rst_err_overflow", DW'(err_overflow), DW'(0));
    check_output("rst_err_protocol", DW'(err_protocol), DW'(0));
    rst = 1'b0;

    $display("[TB] overwrite pass");
    do_start(1'b0, 1'b1);
    check_output("ovw_busy", DW'(busy), DW'(1));
    first_seen = -1;
    push_expected(E_IDX, 0, ROWS - 1);
    apply_stimulus(ROWS, P_IDX);
    wait_idle("ovw_idle", 100);
    check_output("ovw_latency", DW'(first_seen - t_feed), DW'(4));
    check_output("ovw_sb_empty", DW'(sb.size()), DW'(0));

    $display("[TB] accumulate passes");
    do_start(1'b0, 1'b0);
    apply_stimulus(ROWS, P_FIVE);
    wait_idle("acc1_idle", 100);
    do_start(1'b1, 1'b1);
    push_expected(E_TWELVE, 0, ROWS - 1);
    apply_stimulus(ROWS, P_SEVEN);
    wait_idle("acc2_idle", 100);
    check_output("acc_sb_empty", DW'(sb.size()), DW'(0));

    $display("[TB] wrap");
    do_start(1'b0, 1'b0);
    apply_stimulus(ROWS, P_BIG);
    wait_idle("wrap1_idle", 100);
    do_start(1'b1, 1'b1);
    push_expected(E_WRAP, 0, ROWS - 1);
    apply_stimulus(ROWS, P_ONE);
    wait_idle("wrap2_idle", 100);
    check_output("wrap_err_overflow", DW'(err_overflow), DW'(0));
    check_output("wrap_err_protocol", DW'(err_protocol), DW'(0));
    check_output("wrap_sb_empty", DW'(sb.size()), DW'(0));

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    do_start(1'b0, 1'b1);
    push_expected(E_IDX, 0, FD - 1);
    apply_stimulus(ROWS, P_IDX);
    repeat (5) @(posedge clk);
    #1;
    check_output("bp_busy_flush", DW'(busy), DW'(1));
    check_output("bp_err_overflow", DW'(err_overflow), DW'(1));
    check_output("bp_out_valid", DW'(bus.out_valid), DW'(1));
    check_output("bp_head_row", DW'(bus.out_row), DW'(0));
    check_output("bp_head_data", bus.out_data, exp_row(E_IDX, 0));
    repeat (3) @(posedge clk);
    #1;
    check_output("bp_head_row_hold", DW'(bus.out_row), DW'(0));
    check_output("bp_head_data_hold", bus.out_data, exp_row(E_IDX, 0));
    check_output("bp_busy_hold", DW'(busy), DW'(1));
    bus.out_ready = 1'b1;
    wait_idle("bp_idle", 100);
    check_output("bp_sb_empty", DW'(sb.size()), DW'(0));
    check_output("bp_err_sticky", DW'(err_overflow), DW'(1));

    $display("[TB] protocol");
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("prot_idle_err", DW'(err_protocol), DW'(1));
    check_output("prot_idle_busy", DW'(busy), DW'(0));
    check_output("prot_idle_out_valid", DW'(bus.out_valid), DW'(0));
    do_start(1'b0, 1'b1);
    check_output("prot_start_clr_protocol", DW'(err_protocol), DW'(0));
    check_output("prot_start_clr_overflow", DW'(err_overflow), DW'(0));
    push_expected(E_IDX, 0, ROWS - 1);
    apply_stimulus(ROWS + 1, P_IDX);
    wait_idle("prot_idle", 100);
    check_output("prot_17th_err", DW'(err_protocol), DW'(1));
    check_output("prot_sb_empty", DW'(sb.size()), DW'(0));

    $display("[TB] reset mid-pass");
    bus.out_ready = 1'b0;
    do_start(1'b0, 1'b1);
    apply_stimulus(5, P_IDX);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
    check_output("mid_rst_busy", DW'(busy), DW'(0));
    check_output("mid_rst_err_overflow", DW'(err_overflow), DW'(0));
    check_output("mid_rst_err_protocol", DW'(err_protocol), DW'(0));
    bus.out_ready = 1'b1;
    do_start(1'b0, 1'b1);
    first_seen = -1;
    push_expected(E_IDX, 0, ROWS - 1);
    apply_stimulus(ROWS, P_IDX);
    wait_idle("post_rst_idle", 100);
    check_output("post_rst_latency", DW'(first_seen - t_feed), DW'(4));
    check_output("post_rst_sb_empty", DW'(sb.size()), DW'(0));
    check_output("post_rst_err_overflow", DW'(err_overflow), DW'(0));
    check_output("post_rst_err_protocol", DW'(err_protocol), DW'(0));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
